// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access size codes, FSM state
// encodings and the captured request control bundle.
package load_store_unit_pkg;

  localparam logic LSU_SIZE_BYTE = 1'b0;
  localparam logic LSU_SIZE_WORD = 1'b1;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_STORE  = 3'd2,
    LSU_RMW_RD = 3'd3,
    LSU_RMW_WR = 3'd4,
    LSU_RESP   = 3'd5
  } lsu_state_e;

  typedef struct packed {
    logic write;
    logic size;
    logic sgn;
  } lsu_ctl_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper for the load/store unit.
//   word_i  : memory word (read data, or the RMW merge buffer)
//   lane_i  : byte lane select (byte address bit 0; 1 = upper lane)
//   sgn_i   : sign-extend the selected byte on loads
//   byte_i  : byte to insert on stores
//   load_o  : selected byte, zero/sign extended to the word width
//   merge_o : word_i with the selected lane replaced by byte_i
module lsu_byte_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic              lane_i,
  input  logic              sgn_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  localparam int NUM_LANES = DATA_W / 8;

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [NUM_LANES-1:0][7:0] merged;
  logic [7:0]                sel;

  assign lanes = word_i;
  assign sel   = lanes[lane_i];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged[g] = (lane_i == 1'(g)) ? byte_i : lanes[g];
  end

  assign load_o  = {{(DATA_W-8){sgn_i & sel[7]}}, sel};
  assign merge_o = merged;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-organised data memory.
// Accepts one request at a time (req_valid/req_ready), performs a word or
// byte load/store (byte stores via read-modify-write) and returns a
// one-cycle response (resp_valid/resp_rdata/resp_err).
//   clk, rst_n          : clock, async active-low reset
//   req_*               : core request (write, size, signed, addr, wdata)
//   resp_*              : completion pulse, load data, misalignment error
//   mem_read/mem_write  : memory enables (never both high)
//   mem_addr/mem_wdata  : word-aligned byte address, write data
//   mem_rdata           : combinational read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  lsu_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
  logic              err_q;

  logic              accept, misalign;
  logic [DATA_W-1:0] lane_word, lane_load, lane_merge;

  assign accept   = req_valid && (state_q == LSU_IDLE);
  assign misalign = (req_size == LSU_SIZE_WORD) && req_addr[0];

  // The lane helper formats read data on loads and merges the store byte
  // into the buffered word during the RMW write phase.
  assign lane_word = (state_q == LSU_RMW_WR) ? merge_q : mem_rdata;

  lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
    .word_i  (lane_word),
    .lane_i  (addr_q[0]),
    .sgn_i   (ctl_q.sgn),
    .byte_i  (wdata_q[7:0]),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (req_valid) begin
        if (misalign)                        state_d = LSU_RESP;
        else if (!req_write)                 state_d = LSU_LOAD;
        else if (req_size == LSU_SIZE_WORD)  state_d = LSU_STORE;
        else                                 state_d = LSU_RMW_RD;
      end
      LSU_LOAD, LSU_STORE, LSU_RMW_WR: state_d = LSU_RESP;
      LSU_RMW_RD:                      state_d = LSU_RMW_WR;
      LSU_RESP:                        state_d = LSU_IDLE;
      default:                         state_d = LSU_IDLE;
    endcase
  end

  // Request capture and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q   <= '{write: req_write, size: req_size, sgn: req_signed};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misalign;
        rdata_q <= '0;   // stores and errors respond with zero data
      end
      if (state_q == LSU_LOAD)
        rdata_q <= (ctl_q.size == LSU_SIZE_WORD) ? mem_rdata : lane_load;
      if (state_q == LSU_RMW_RD)
        merge_q <= mem_rdata;
    end
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == LSU_IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      LSU_LOAD, LSU_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:1], 1'b0};
      end
      LSU_STORE: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
        mem_wdata = wdata_q;
      end
      LSU_RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
        mem_wdata = lane_merge;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_size, req_signed;
  logic [8:0]  req_addr, mem_addr;
  logic [15:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, mem_read, mem_write;

  load_store_unit #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // word memory model
  logic [15:0] mem [256];
  assign mem_rdata = mem_read ? mem[mem_addr[8:1]] : 16'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[8:1]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // results of the last do_req
  int          lat, nrd, nwr, both_tot;
  logic [15:0] rdat, wdat;
  logic [8:0]  waddr;
  logic        err;

  task automatic do_req(input logic w, input logic sz, input logic sg,
                        input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    chk("ready_idle", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rdat = 16'h0; err = 1'b0; waddr = 9'h0; wdat = 16'h0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; waddr = mem_addr; wdat = mem_wdata; end
      if (mem_read && mem_write) both_tot++;
      if (resp_valid) begin lat = n; rdat = resp_rdata; err = resp_err; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  rp, vp;
    logic [15:0] r0, r1;
    int          nresp;
    both_tot = 0;
    // reset held with a pending request
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_signed = 1'b0;
    req_addr = 9'h002; req_wdata = 16'h1111;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp", resp_valid, 0);
      chk("rst_rd", mem_read, 0);
      chk("rst_wr", mem_write, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_acc_wr", mem_write, 1);
    chk("first_acc_addr", mem_addr, 9'h002);
    chk("first_acc_ready", req_ready, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("first_acc_resp", resp_valid, 1);

    // preload through the unit
    do_req(1, 1, 0, 9'h020, 16'h80FF);
    do_req(1, 1, 0, 9'h030, 16'h1234);
    do_req(1, 1, 0, 9'h1FE, 16'hA53C);
    do_req(1, 1, 0, 9'h040, 16'h1234);

    // word store then load
    do_req(1, 1, 0, 9'h010, 16'hBEEF);
    chk("st_lat", lat, 2);
    chk("st_nwr", nwr, 1);
    chk("st_nrd", nrd, 0);
    chk("st_addr", waddr, 9'h010);
    chk("st_data", wdat, 16'hBEEF);
    chk("st_rdata", rdat, 0);
    do_req(0, 1, 0, 9'h010, 16'h0);
    chk("ld_lat", lat, 2);
    chk("ld_data", rdat, 16'hBEEF);
    chk("ld_err", err, 0);
    chk("ld_nrd", nrd, 1);
    chk("ld_nwr", nwr, 0);

    // byte loads
    do_req(0, 0, 1, 9'h021, 16'h0);
    chk("lb_hi_s", rdat, 16'hFF80);
    chk("lb_lat", lat, 2);
    do_req(0, 0, 0, 9'h021, 16'h0);
    chk("lb_hi_u", rdat, 16'h0080);
    do_req(0, 0, 1, 9'h020, 16'h0);
    chk("lb_lo_s", rdat, 16'hFFFF);
    do_req(0, 0, 0, 9'h1FF, 16'h0);
    chk("lb_top_u", rdat, 16'h00A5);
    do_req(0, 0, 1, 9'h1FE, 16'h0);
    chk("lb_top_lo_s", rdat, 16'h003C);

    // byte store (RMW)
    do_req(1, 0, 0, 9'h031, 16'h0055);
    chk("sb_lat", lat, 3);
    chk("sb_nrd", nrd, 1);
    chk("sb_nwr", nwr, 1);
    chk("sb_addr", waddr, 9'h030);
    chk("sb_data", wdat, 16'h5534);
    do_req(0, 1, 0, 9'h030, 16'h0);
    chk("sb_readback", rdat, 16'h5534);

    // misaligned word accesses
    do_req(0, 1, 0, 9'h013, 16'h0);
    chk("mis_ld_lat", lat, 1);
    chk("mis_ld_err", err, 1);
    chk("mis_ld_data", rdat, 0);
    chk("mis_ld_mem", nrd + nwr, 0);
    do_req(1, 1, 0, 9'h013, 16'hDEAD);
    chk("mis_st_err", err, 1);
    chk("mis_st_mem", nrd + nwr, 0);

    // back-to-back with req_valid held
    @(negedge clk);
    req_write = 1'b0; req_size = 1'b1; req_signed = 1'b0; req_addr = 9'h010;
    req_valid = 1'b1;
    rp = '0; vp = '0; r0 = '0; r1 = '0; nresp = 0;
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      rp[n] = req_ready;
      vp[n] = resp_valid;
      if (resp_valid) begin
        if (nresp == 0) r0 = resp_rdata; else r1 = resp_rdata;
        nresp++;
      end
      if (n == 1) req_addr = 9'h030;
      if (n == 5) req_valid = 1'b0;
    end
    chk("b2b_ready", rp, 7'b1001001);
    chk("b2b_resp", vp, 7'b0100100);
    chk("b2b_r0", r0, 16'hBEEF);
    chk("b2b_r1", r1, 16'h5534);

    // reset during RMW_WR
    @(negedge clk);
    req_write = 1'b1; req_size = 1'b0; req_signed = 1'b0; req_addr = 9'h041;
    req_wdata = 16'h00AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("ab_rmwrd", mem_read, 1);
    @(negedge clk);
    chk("ab_rmwwr", mem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("ab_wr_drop", mem_write, 0);
    chk("ab_resp_drop", resp_valid, 0);
    nresp = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid || mem_write) nresp++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_write) nresp++;
    end
    chk("ab_no_resp", nresp, 0);
    do_req(0, 1, 0, 9'h040, 16'h0);
    chk("ab_mem_kept", rdat, 16'h1234);

    chk("never_both", both_tot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
